// File: rtl/data_memory.sv
// RV32I load/store data memory: byte-addressed, little-endian, word-organised.
// Loads are combinational with sign/zero extension. Stores update only the
// addressed byte lanes on the rising clock edge. Reset asynchronously clears
// every word.
module data_memory #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemW,
  input  logic [2:0]  funct3,
  output logic [31:0] ReadData
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [1:0]    byte_lane;
  logic          half_lane;
  logic [31:0]   cur_word;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic [31:0]   word_d;
  logic          wr_en_d;
  logic          unused_addr;

  // Upper address bits are ignored, so accesses wrap modulo capacity.
  assign word_idx    = Address[AW+1:2];
  assign byte_lane   = Address[1:0];
  assign half_lane   = Address[1];
  assign unused_addr = ^Address[31:AW+2];

  assign cur_word = mem_q[word_idx];
  assign sel_byte = cur_word[{byte_lane, 3'b000} +: 8];
  assign sel_half = cur_word[{half_lane, 4'b0000} +: 16];

  // Load path: pick the addressed lane and extend it; forced to zero during reset.
  always_comb begin
    ReadData = 32'h0;
    if (!RST) begin
      case (funct3)
        3'b000:  ReadData = {{24{sel_byte[7]}}, sel_byte};
        3'b001:  ReadData = {{16{sel_half[15]}}, sel_half};
        3'b010:  ReadData = cur_word;
        3'b100:  ReadData = {24'h0, sel_byte};
        3'b101:  ReadData = {16'h0, sel_half};
        default: ReadData = 32'h0;
      endcase
    end
  end

  // Store merge: build the updated word so untouched lanes keep their value.
  always_comb begin
    word_d  = cur_word;
    wr_en_d = 1'b0;
    if (MemW && !RST) begin
      case (funct3)
        3'b000: begin
          word_d[{byte_lane, 3'b000} +: 8] = WriteData[7:0];
          wr_en_d = 1'b1;
        end
        3'b001: begin
          word_d[{half_lane, 4'b0000} +: 16] = WriteData[15:0];
          wr_en_d = 1'b1;
        end
        3'b010: begin
          word_d  = WriteData;
          wr_en_d = 1'b1;
        end
        default: begin
          word_d  = cur_word;
          wr_en_d = 1'b0;
        end
      endcase
    end
  end

  // Storage: async clear of every word; otherwise commit the merged word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (wr_en_d) begin
      mem_q[word_idx] <= word_d;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: a byte-array reference model predicts each
// load; a monitor compares ReadData on the falling edge.
module tb_data_memory;

  localparam int DEPTH = 256;
  localparam int CAP   = 4 * DEPTH;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        memw;
  logic [2:0]  f3;
  logic [31:0] rdata;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] addr;
    logic [2:0]  f3;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mb [CAP];

  data_memory #(.DEPTH_WORDS(DEPTH)) dut (
    .CLK      (clk),
    .RST      (rst),
    .Address  (addr),
    .WriteData(wdata),
    .MemW     (memw),
    .funct3   (f3),
    .ReadData (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void m_clear();
    for (int i = 0; i < CAP; i++) mb[i] = 8'h0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [2:0] f, input logic r);
    int unsigned b, h, w;
    logic [15:0] hv;
    b  = a % CAP;
    h  = b & ~32'd1;
    w  = b & ~32'd3;
    hv = {mb[h + 1], mb[h]};
    if (r) return 32'h0;
    case (f)
      3'd0:    return {{24{mb[b][7]}}, mb[b]};
      3'd1:    return {{16{hv[15]}}, hv};
      3'd2:    return {mb[w + 3], mb[w + 2], mb[w + 1], mb[w]};
      3'd4:    return {24'h0, mb[b]};
      3'd5:    return {16'h0, hv};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    int unsigned b, h, w;
    b = a % CAP;
    h = b & ~32'd1;
    w = b & ~32'd3;
    case (f)
      3'd0: mb[b] = d[7:0];
      3'd1: begin mb[h] = d[7:0]; mb[h + 1] = d[15:8]; end
      3'd2: begin
        mb[w] = d[7:0]; mb[w + 1] = d[15:8]; mb[w + 2] = d[23:16]; mb[w + 3] = d[31:24];
      end
      default: ;
    endcase
  endfunction

  // One access: drive just after a rising edge, predict the load from the
  // pre-edge model, then let the edge commit any store.
  task automatic cycle(input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic [2:0] f);
    exp_t e;
    rst   = r;
    addr  = a;
    wdata = d;
    memw  = w;
    f3    = f;
    if (r) m_clear();
    e.exp  = m_read(a, f, r);
    e.addr = a;
    e.f3   = f;
    exp_q.push_back(e);
    @(posedge clk);
    if (w && !r) m_write(a, d, f);
    #1;
  endtask

  // Monitor: the load result is combinational, so it is sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (rdata !== e.exp) begin
        errors++;
        $display("FAIL read addr=%h f3=%0d got=%h exp=%h", e.addr, e.f3, rdata, e.exp);
      end
    end
  end

  initial begin
    rst = 1'b1; addr = 0; wdata = 0; memw = 0; f3 = 0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    // Reads during reset, then post-reset read with a non-enabled store.
    cycle(1, 32'h8, 32'h0007F7DF, 1, 3'b010);
    cycle(0, 32'h8, 32'h0007F7DF, 0, 3'b000);
    cycle(0, 32'h8, 32'h0, 0, 3'b010);
    // SW/LW and sized loads of the same word.
    cycle(0, 32'h10, 32'h876543A1, 1, 3'b010);
    cycle(0, 32'h10, 32'h0, 0, 3'b010);
    cycle(0, 32'h10, 32'h0, 0, 3'b000);
    cycle(0, 32'h13, 32'h0, 0, 3'b100);
    cycle(0, 32'h12, 32'h0, 0, 3'b001);
    cycle(0, 32'h10, 32'h0, 0, 3'b101);
    // Lane merge.
    cycle(0, 32'h20, 32'h0, 1, 3'b010);
    cycle(0, 32'h21, 32'h123456AB, 1, 3'b000);
    cycle(0, 32'h22, 32'h9876CDEF, 1, 3'b001);
    cycle(0, 32'h20, 32'h0, 0, 3'b010);
    // Protection: MemW low, and unsupported funct3 with MemW high.
    for (int i = 0; i < 4; i++) cycle(0, 32'h20, 32'hFFFFFFFF, 0, 3'(i));
    cycle(0, 32'h20, 32'hFFFFFFFF, 1, 3'b011);
    cycle(0, 32'h20, 32'hFFFFFFFF, 1, 3'b111);
    cycle(0, 32'h20, 32'h0, 0, 3'b011);
    cycle(0, 32'h20, 32'h0, 0, 3'b010);
    // Wrap and misalignment.
    cycle(0, 32'h0, 32'h12345678, 1, 3'b010);
    cycle(0, CAP, 32'h0, 0, 3'b010);
    cycle(0, 32'h3, 32'h0, 0, 3'b010);
    cycle(0, 32'h1, 32'h0, 0, 3'b001);
    // Randomised traffic over a small window with random upper address bits.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      cycle(0, a, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end
    // Async reset mid-run, then every word must read back as zero.
    cycle(0, 32'h10, 32'h0, 0, 3'b010);
    cycle(1, 32'h10, 32'hDEADBEEF, 1, 3'b010);
    cycle(1, 32'h20, 32'hDEADBEEF, 1, 3'b010);
    for (int i = 0; i < DEPTH; i++) cycle(0, 32'(4 * i), 32'h0, 0, 3'b010);
    // A little more random traffic after reset.
    for (int i = 0; i < 100; i++) begin
      cycle(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      cycle(0, $urandom, 32'h0, 0, 3'($urandom_range(0, 7)));
    end
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
